// File: rtl/shift32_pkg.sv
// shift32_pkg: shared encodings for the iterative 32-bit shift unit.
//   - shift32_ctr operation codes (SLL, SRL, SRA, LUI)
//   - FSM state encoding for shift32_unit
//   - fixed LUI shift amount
package shift32_pkg;

    localparam logic [1:0] SH_SLL = 2'b00;
    localparam logic [1:0] SH_SRL = 2'b01;
    localparam logic [1:0] SH_SRA = 2'b10;
    localparam logic [1:0] SH_LUI = 2'b11;

    localparam logic [4:0] LUI_AMT = 5'd16;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/shift32_step.sv
// shift32_step: one combinational shift step of the accumulator.
// Ports:
//   acc_i   [31:0] current accumulator
//   k_i     [4:0]  bits to shift this step
//   op_i    [1:0]  shift32_ctr code (SLL/LUI shift left, SRL/SRA shift right)
//   sign_i         fill bit for SRA (sign of the original operand)
//   acc_o   [31:0] shifted accumulator
module shift32_step
    import shift32_pkg::*;
(
    input  logic [31:0] acc_i,
    input  logic [4:0]  k_i,
    input  logic [1:0]  op_i,
    input  logic        sign_i,
    output logic [31:0] acc_o
);

    // Ones in the top k bit positions: the bits vacated by a right shift.
    logic [31:0] fill_mask;

    always_comb begin
        fill_mask = ~(32'hFFFF_FFFF >> k_i);
        acc_o     = acc_i;
        case (op_i)
            SH_SLL, SH_LUI: acc_o = acc_i << k_i;
            SH_SRL:         acc_o = acc_i >> k_i;
            SH_SRA:         acc_o = (acc_i >> k_i) | (fill_mask & {32{sign_i}});
            default:        acc_o = acc_i;
        endcase
    end

endmodule

// File: rtl/shift32_unit.sv
// shift32_unit: multi-cycle 32-bit shift execution unit (EX stage, beside the ALU).
// Accepts one operation per in_valid/in_ready handshake, shifts STEP bits per
// cycle, and presents the result on an out_valid/out_ready handshake.
// Parameters:
//   STEP  bits shifted per BUSY cycle (power of two, 1..16)
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   in_valid / in_ready     operation handshake (in_ready only in IDLE, not in reset)
//   shift32_ctr [1:0]       00 SLL, 01 SRL, 10 SRA, 11 LUI (shift left 16, shamt ignored)
//   shamt [4:0], data_in    shift amount and operand
//   out_valid / out_ready   result handshake
//   data_out [31:0]         result, stable while out_valid
//   busy                    high in BUSY or DONE
//   zero                    registered data_out==0 flag; exists only when
//                           SHIFT32_ZERO_FLAG_EN is defined
module shift32_unit
    import shift32_pkg::*;
#(
    parameter int unsigned STEP = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  shift32_ctr,
    input  logic [4:0]  shamt,
    input  logic [31:0] data_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] data_out,
    output logic        busy
`ifdef SHIFT32_ZERO_FLAG_EN
    ,
    output logic        zero
`endif
);

    localparam logic [4:0] STEP_K = 5'(STEP);

    state_e      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [4:0]  rem_q, rem_d;
    logic [1:0]  op_q, op_d;
    logic        sign_q, sign_d;

    logic [4:0]  k;
    logic [31:0] step_acc;

    assign k = (rem_q < STEP_K) ? rem_q : STEP_K;

    shift32_step u_step (
        .acc_i  (acc_q),
        .k_i    (k),
        .op_i   (op_q),
        .sign_i (sign_q),
        .acc_o  (step_acc)
    );

    assign in_ready  = (state_q == S_IDLE) && !reset;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign data_out  = acc_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        op_d    = op_q;
        sign_d  = sign_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    acc_d   = data_in;
                    op_d    = shift32_ctr;
                    sign_d  = data_in[31];
                    rem_d   = (shift32_ctr == SH_LUI) ? LUI_AMT : shamt;
                    state_d = (rem_d == '0) ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                acc_d = step_acc;
                rem_d = rem_q - k;
                if (rem_d == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            op_q    <= '0;
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
            sign_q  <= sign_d;
        end
    end

`ifdef SHIFT32_ZERO_FLAG_EN
    logic zero_q;

    // Captured from the final accumulator value on the edge that enters DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            zero_q <= 1'b0;
        end else if (state_q != S_DONE && state_d == S_DONE) begin
            zero_q <= (acc_d == '0);
        end else if (state_q == S_DONE && state_d != S_DONE) begin
            zero_q <= 1'b0;
        end
    end

    assign zero = zero_q;
`endif

endmodule

// File: tb/tb_shift32_unit.sv
module tb_shift32_unit;

    localparam int unsigned TB_STEP = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [1:0]  shift32_ctr = 2'b00;
    logic [4:0]  shamt = 5'd0;
    logic [31:0] data_in = 32'h0;
    logic        in_ready;
    logic        out_valid;
    logic        busy;
    logic [31:0] data_out;
`ifdef SHIFT32_ZERO_FLAG_EN
    logic        zero;
`endif

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;
    bit          chk_en  = 1'b0;

    always #5 clk = ~clk;

    shift32_unit #(.STEP(TB_STEP)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .shift32_ctr (shift32_ctr),
        .shamt       (shamt),
        .data_in     (data_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .data_out    (data_out),
        .busy        (busy)
`ifdef SHIFT32_ZERO_FLAG_EN
        ,
        .zero        (zero)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%h required=%h", name, act, exp);
    endtask

    // Reference result straight from the operation definitions.
    function automatic logic [31:0] ref_shift(input logic [1:0] c, input logic [4:0] s,
                                              input logic [31:0] d);
        logic signed [31:0] sd;
        sd = d;
        case (c)
            2'b00:   return d << s;
            2'b01:   return d >> s;
            2'b10:   return sd >>> s;
            default: return {d[15:0], 16'h0000};
        endcase
    endfunction

    // Number of shifting cycles: ceil(amount / STEP).
    function automatic int unsigned ref_cycles(input logic [1:0] c, input logic [4:0] s);
        int unsigned amt;
        amt = (c == 2'b11) ? 16 : int'(s);
        return (amt + TB_STEP - 1) / TB_STEP;
    endfunction

    // Transaction-level model: 0 idle, 1 working (countdown), 2 result held.
    int unsigned m_phase = 0;
    int unsigned m_cnt   = 0;
    logic [31:0] m_res   = 32'h0;
    logic [31:0] m_out   = 32'h0;
    bit          m_known = 1'b1;

    always @(posedge clk) begin
        if (reset) begin
            m_phase <= 0;
            m_out   <= 32'h0;
            m_known <= 1'b1;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_res <= ref_shift(shift32_ctr, shamt, data_in);
                    if (ref_cycles(shift32_ctr, shamt) == 0) begin
                        m_phase <= 2;
                        m_out   <= ref_shift(shift32_ctr, shamt, data_in);
                        m_known <= 1'b1;
                    end else begin
                        m_phase <= 1;
                        m_cnt   <= ref_cycles(shift32_ctr, shamt);
                        m_known <= 1'b0;
                    end
                end
                1: begin
                    m_cnt <= m_cnt - 1;
                    if (m_cnt == 1) begin
                        m_phase <= 2;
                        m_out   <= m_res;
                        m_known <= 1'b1;
                    end
                end
                default: if (out_ready) m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", 32'(out_valid), 32'(m_phase == 2));
            check("busy", 32'(busy), 32'(m_phase != 0));
            check("in_ready", 32'(in_ready), 32'(m_phase == 0 && !reset));
            if (m_known) check("data_out", data_out, m_out);
`ifdef SHIFT32_ZERO_FLAG_EN
            check("zero", 32'(zero), 32'(m_phase == 2 && m_out == 32'h0));
`endif
        end
    end

    task automatic run_op(input string name, input logic [1:0] c, input logic [4:0] s,
                          input logic [31:0] d, input logic [31:0] exp_d,
                          input int unsigned exp_lat, input int unsigned hold);
        int unsigned lat;
        bit          got;
        lat = 0;
        got = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1; shift32_ctr = c; shamt = s; data_in = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        shift32_ctr = 2'($urandom); shamt = 5'($urandom); data_in = $urandom;
        while (!got && lat < 64) begin
            @(negedge clk);
            lat++;
            got = out_valid;
        end
        check({name, " out_valid seen"}, 32'(got), 32'd1);
        check({name, " latency"}, lat, exp_lat);
        check({name, " data"}, data_out, exp_d);
`ifdef SHIFT32_ZERO_FLAG_EN
        check({name, " zero"}, 32'(zero), 32'(exp_d == 32'h0));
`endif
        for (int i = 0; i < int'(hold); i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; shift32_ctr = 2'b00; shamt = 5'd1; data_in = 32'hFFFF_FFFF;
            @(negedge clk);
            check({name, " hold data"}, data_out, exp_d);
            check({name, " hold in_ready"}, 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check({name, " released"}, 32'(out_valid), 32'd0);
        check({name, " idle again"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        check("reset in_ready", 32'(in_ready), 32'd0);
        check("reset data_out", data_out, 32'h0);
        check("reset out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Model pinned against hand-computed literals.
        check("model SRA", ref_shift(2'b10, 5'd4, 32'h8000_00F0), 32'hF800_000F);
        check("model LUI", ref_shift(2'b11, 5'd7, 32'h1234_ABCD), 32'hABCD_0000);
        check("model cycles 31", ref_cycles(2'b00, 5'd31), 32'd8);

        run_op("SLL 1<<31",   2'b00, 5'd31, 32'h0000_0001, 32'h8000_0000, 9, 0);
        run_op("SRA F0>>4",   2'b10, 5'd4,  32'h8000_00F0, 32'hF800_000F, 2, 0);
        run_op("SRL F0>>4",   2'b01, 5'd4,  32'h8000_00F0, 32'h0800_000F, 2, 0);
        run_op("LUI",         2'b11, 5'd7,  32'h1234_ABCD, 32'hABCD_0000, 5, 0);
        run_op("SRL shamt0",  2'b01, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 0);
        run_op("SRA 31",      2'b10, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 9, 0);
        run_op("SRA 3",       2'b10, 5'd3,  32'h8000_00F0, 32'hF000_001E, 2, 0);
        run_op("SRA pos 8",   2'b10, 5'd8,  32'h7FFF_FFFF, 32'h007F_FFFF, 3, 0);
        run_op("SLL 5",       2'b00, 5'd5,  32'h1234_5678, 32'h468A_CF00, 3, 0);
        run_op("SRL 16",      2'b01, 5'd16, 32'hFFFF_0000, 32'h0000_FFFF, 5, 0);
        run_op("SRL to zero", 2'b01, 5'd4,  32'h0000_000F, 32'h0000_0000, 2, 0);
        run_op("backpressure", 2'b00, 5'd8, 32'h0000_00A5, 32'h0000_A500, 3, 5);

        // Reset while shifting discards the operation.
        @(posedge clk); #1;
        in_valid = 1'b1; shift32_ctr = 2'b00; shamt = 5'd31; data_in = 32'h0000_0001;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("mid-op busy before reset edge", 32'(busy), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("after reset out_valid", 32'(out_valid), 32'd0);
        check("after reset data_out", data_out, 32'h0);
        check("after reset busy", 32'(busy), 32'd0);
        check("after reset in_ready", 32'(in_ready), 32'd1);
        repeat (12) @(negedge clk);
        check("no late result", 32'(out_valid), 32'd0);

        run_op("post-reset SRL", 2'b01, 5'd1, 32'h0000_0002, 32'h0000_0001, 2, 0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
